// File: rtl/vscale_mul_div_param_pkg.sv
// Shared encodings and state type for the iterative multiply/divide unit.
package vscale_mul_div_param_pkg;

    localparam int MD_OP_WIDTH      = 2;
    localparam int MD_OUT_SEL_WIDTH = 2;

    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO  = 2'd0;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI  = 2'd1;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_REM = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        SETUP   = 2'd2,
        DONE    = 2'd3
    } md_state_e;

endpackage

// File: rtl/vscale_md_abs_neg.sv
// Conditional two's-complement negate: used both to take operand magnitudes
// and to restore the sign of the final result.
module vscale_md_abs_neg #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] value,
    input  logic            negate,
    output logic [XLEN-1:0] result
);

    assign result = negate ? (~value + {{(XLEN-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/vscale_mul_div_param.sv
// Iterative one-bit-per-cycle multiplier / restoring divider with
// valid/ready request and response handshakes.
module vscale_mul_div_param
    import vscale_mul_div_param_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int LOG2_XLEN = $clog2(XLEN)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [MD_OP_WIDTH-1:0]      req_op,
    input  logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel,
    input  logic                        req_in_1_signed,
    input  logic                        req_in_2_signed,
    input  logic [XLEN-1:0]             req_in_1,
    input  logic [XLEN-1:0]             req_in_2,
    input  logic                        req_kill,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [XLEN-1:0]             resp_result,
    output logic                        resp_div_zero,
    output logic [1:0]                  dbg_state
);

    // A request transfers when req_valid and req_ready are both high at a
    // rising edge (and req_kill is low); a response transfers when
    // resp_valid and resp_ready are both high. Each side holds until then.

    md_state_e                   state, state_next;
    logic [MD_OP_WIDTH-1:0]      op_r;
    logic [MD_OUT_SEL_WIDTH-1:0] out_sel_r;
    logic [LOG2_XLEN-1:0]        counter;
    logic [2*XLEN-1:0]           acc;
    logic [XLEN-1:0]             op_b;
    logic                        negate_r, rem_neg_r, div_zero_r;

    logic              accept, req_div, div_zero_req, sign_1, sign_2;
    logic [XLEN-1:0]   abs_1, abs_2;
    logic [XLEN:0]     mul_sum, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, neg_in, neg_out;
    logic              neg_flag;
    logic [XLEN-1:0]   sel_result;

    assign accept       = (state == IDLE) && req_valid && !req_kill;
    assign req_div      = (req_op == MD_OP_DIV) || (req_op == MD_OP_REM);
    assign div_zero_req = req_div && (req_in_2 == '0);
    assign sign_1       = req_in_1_signed & req_in_1[XLEN-1];
    assign sign_2       = req_in_2_signed & req_in_2[XLEN-1];
    assign dbg_state    = state;

    vscale_md_abs_neg #(.XLEN(XLEN)) u_abs_1 (.value(req_in_1), .negate(sign_1), .result(abs_1));
    vscale_md_abs_neg #(.XLEN(XLEN)) u_abs_2 (.value(req_in_2), .negate(sign_2), .result(abs_2));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = div_zero_req ? SETUP : COMPUTE;
            COMPUTE: if (req_kill) state_next = IDLE;
                     else if (counter == '0) state_next = SETUP;
            SETUP:   state_next = req_kill ? IDLE : DONE;
            DONE:    if (req_kill || resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_next;
            req_ready  <= (state_next == IDLE);
            resp_valid <= (state_next == DONE);
        end
    end

    // acc is {remainder/high, quotient/low}; both algorithms shift through it.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_b} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc[XLEN-1:1]};
    assign div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, op_b};
    assign div_next = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    always_comb begin
        neg_in   = '0;
        neg_flag = 1'b0;
        case (op_r)
            MD_OP_MUL: begin neg_in = acc;                          neg_flag = negate_r;  end
            MD_OP_DIV: begin neg_in = {{XLEN{1'b0}}, acc[XLEN-1:0]};  neg_flag = negate_r;  end
            MD_OP_REM: begin neg_in = {{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]}; neg_flag = rem_neg_r; end
            default: ;
        endcase
    end

    vscale_md_abs_neg #(.XLEN(2*XLEN)) u_res_neg (.value(neg_in), .negate(neg_flag), .result(neg_out));

    // DIV/REM choose quotient/remainder by op; out_sel only splits the product.
    always_comb begin
        sel_result = '0;
        if (out_sel_r != 2'd3) begin
            case (op_r)
                MD_OP_MUL: sel_result = (out_sel_r == MD_OUT_HI) ? neg_out[2*XLEN-1:XLEN] :
                                        (out_sel_r == MD_OUT_LO) ? neg_out[XLEN-1:0] : '0;
                MD_OP_DIV,
                MD_OP_REM: sel_result = neg_out[XLEN-1:0];
                default:   sel_result = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r          <= '0;
            out_sel_r     <= '0;
            counter       <= '0;
            acc           <= '0;
            op_b          <= '0;
            negate_r      <= 1'b0;
            rem_neg_r     <= 1'b0;
            div_zero_r    <= 1'b0;
            resp_result   <= '0;
            resp_div_zero <= 1'b0;
        end else if (accept) begin
            op_r       <= req_op;
            out_sel_r  <= req_out_sel;
            counter    <= LOG2_XLEN'(XLEN-1);
            op_b       <= abs_2;
            div_zero_r <= div_zero_req;
            if (div_zero_req) begin
                acc       <= {req_in_1, {XLEN{1'b1}}};
                negate_r  <= 1'b0;
                rem_neg_r <= 1'b0;
            end else begin
                acc       <= {{XLEN{1'b0}}, abs_1};
                negate_r  <= sign_1 ^ sign_2;
                rem_neg_r <= sign_1;
            end
        end else if (state == COMPUTE) begin
            acc <= (op_r == MD_OP_MUL) ? mul_next : div_next;
            if (counter != '0) counter <= counter - LOG2_XLEN'(1);
        end else if (state == SETUP && !req_kill) begin
            resp_result   <= sel_result;
            resp_div_zero <= div_zero_r;
        end
    end

endmodule

// File: tb/tb_vscale_mul_div_param.sv
// Directed bench for vscale_mul_div_param with a queue-based scoreboard.
module tb_vscale_mul_div_param;
    import vscale_mul_div_param_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [1:0]      req_op = '0;
    logic [1:0]      req_out_sel = '0;
    logic            req_in_1_signed = 1'b0;
    logic            req_in_2_signed = 1'b0;
    logic [XLEN-1:0] req_in_1 = '0;
    logic [XLEN-1:0] req_in_2 = '0;
    logic            req_kill = 1'b0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [XLEN-1:0] resp_result;
    logic            resp_div_zero;
    logic [1:0]      dbg_state;

    vscale_mul_div_param #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_out_sel(req_out_sel),
        .req_in_1_signed(req_in_1_signed), .req_in_2_signed(req_in_2_signed),
        .req_in_1(req_in_1), .req_in_2(req_in_2), .req_kill(req_kill),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_div_zero(resp_div_zero), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    logic [XLEN:0] exp_q[$];
    int            lat_q[$];
    int            acc_q[$];
    string         name_q[$];
    bit            prev_valid = 1'b0;
    logic [XLEN:0] mon_exp;
    int            mon_lat, mon_acc;
    string         mon_name;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: compares each new response against the head of the queue.
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (resp_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=%h required=none", resp_result);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_lat  = lat_q.pop_front();
                mon_acc  = acc_q.pop_front();
                mon_name = name_q.pop_front();
                check({mon_name, "_result"}, resp_result, mon_exp[XLEN-1:0]);
                check({mon_name, "_div_zero"}, XLEN'(resp_div_zero), XLEN'(mon_exp[XLEN]));
                check({mon_name, "_latency"}, XLEN'(ncyc - mon_acc), XLEN'(mon_lat));
            end
        end
        prev_valid = resp_valid;
    end

    task automatic issue(input string name, input logic [1:0] op, input logic [1:0] sel,
                         input logic s1, input logic s2,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp_res, input logic exp_dz,
                         input int exp_lat, input bit track);
        int w = 0;
        @(negedge clk);
        req_op = op; req_out_sel = sel;
        req_in_1_signed = s1; req_in_2_signed = s2;
        req_in_1 = a; req_in_2 = b;
        req_valid = 1'b1;
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout actual=busy required=ready", name);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (track) begin
                exp_q.push_back({exp_dz, exp_res});
                lat_q.push_back(exp_lat);
                acc_q.push_back(ncyc);
                name_q.push_back(name);
            end
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int w = 0;
        while ((exp_q.size() != 0 || resp_valid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout actual=%0d pending required=0", name, exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        // Reset state
        #12;
        check("rst_req_ready", XLEN'(req_ready), 32'd1);
        check("rst_resp_valid", XLEN'(resp_valid), 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_div_zero", XLEN'(resp_div_zero), 32'd0);
        check("rst_state", XLEN'(dbg_state), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        issue("mul_lo_ss",  MD_OP_MUL, MD_OUT_LO, 1, 1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, 34, 1);
        issue("mul_hi_su",  MD_OP_MUL, MD_OUT_HI, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 34, 1);
        issue("mul_hi_ss",  MD_OP_MUL, MD_OUT_HI, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 34, 1);
        issue("mul_hi_uu",  MD_OP_MUL, MD_OUT_HI, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 34, 1);
        issue("mul_lo_uu",  MD_OP_MUL, MD_OUT_LO, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 34, 1);
        issue("div_s_neg7", MD_OP_DIV, MD_OUT_LO, 1, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, 34, 1);
        issue("rem_s_neg7", MD_OP_REM, MD_OUT_REM, 1, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, 34, 1);
        issue("div_ovf",    MD_OP_DIV, MD_OUT_LO, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 34, 1);
        issue("rem_ovf",    MD_OP_REM, MD_OUT_REM, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 34, 1);
        issue("div_zero",   MD_OP_DIV, MD_OUT_LO, 0, 0, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 2, 1);
        issue("rem_zero",   MD_OP_REM, MD_OUT_REM, 0, 0, 32'd5, 32'd0, 32'd5, 1, 2, 1);
        issue("rem_zero_s", MD_OP_REM, MD_OUT_REM, 1, 1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1, 2, 1);
        issue("divu_100_7", MD_OP_DIV, MD_OUT_LO, 0, 0, 32'd100, 32'd7, 32'd14, 0, 34, 1);
        issue("remu_100_7", MD_OP_REM, MD_OUT_REM, 0, 0, 32'd100, 32'd7, 32'd2, 0, 34, 1);
        issue("div_s_negb", MD_OP_DIV, MD_OUT_LO, 1, 1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 34, 1);
        issue("rem_s_negb", MD_OP_REM, MD_OUT_REM, 1, 1, 32'd7, 32'hFFFFFFFE, 32'd1, 0, 34, 1);
        issue("divu_big",   MD_OP_DIV, MD_OUT_LO, 0, 0, 32'hFFFFFFF0, 32'h80000000, 32'd1, 0, 34, 1);
        issue("remu_big",   MD_OP_REM, MD_OUT_REM, 0, 0, 32'hFFFFFFF0, 32'h80000000, 32'h7FFFFFF0, 0, 34, 1);
        issue("divu_small", MD_OP_DIV, MD_OUT_LO, 0, 0, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 34, 1);
        issue("illegal_op", 2'd3, MD_OUT_LO, 0, 0, 32'd9, 32'd3, 32'd0, 0, 34, 1);
        issue("illegal_sel", MD_OP_MUL, 2'd3, 0, 0, 32'd9, 32'd3, 32'd0, 0, 34, 1);
        drain("vectors");

        // Response held while the consumer stalls
        resp_ready = 1'b0;
        issue("hold_mul", MD_OP_MUL, MD_OUT_LO, 0, 0, 32'd6, 32'd7, 32'd42, 0, 34, 1);
        w = 0;
        while (!resp_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("hold_wait", XLEN'(resp_valid), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("hold_result", resp_result, 32'd42);
            check("hold_valid", XLEN'(resp_valid), 32'd1);
            check("hold_req_ready", XLEN'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("hold_release_valid", XLEN'(resp_valid), 32'd0);
        check("hold_release_ready", XLEN'(req_ready), 32'd1);

        // Kill in COMPUTE at cycle 10
        issue("killed", MD_OP_MUL, MD_OUT_LO, 0, 0, 32'd9, 32'd9, 32'd81, 0, 34, 0);
        repeat (9) @(negedge clk);
        req_kill = 1'b1;
        @(negedge clk);
        req_kill = 1'b0;
        check("kill_req_ready", XLEN'(req_ready), 32'd1);
        check("kill_resp_valid", XLEN'(resp_valid), 32'd0);
        repeat (40) @(negedge clk);

        // Kill in IDLE blocks acceptance
        req_op = MD_OP_MUL; req_in_1 = 32'd1; req_in_2 = 32'd1;
        req_valid = 1'b1;
        req_kill  = 1'b1;
        @(negedge clk);
        check("idle_kill_ready", XLEN'(req_ready), 32'd1);
        req_valid = 1'b0;
        req_kill  = 1'b0;

        // Asynchronous reset mid-COMPUTE
        issue("reset_victim", MD_OP_MUL, MD_OUT_LO, 0, 0, 32'd5, 32'd5, 32'd25, 0, 34, 0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_req_ready", XLEN'(req_ready), 32'd1);
        check("midrst_resp_valid", XLEN'(resp_valid), 32'd0);
        check("midrst_result", resp_result, 32'd0);
        check("midrst_div_zero", XLEN'(resp_div_zero), 32'd0);
        check("midrst_state", XLEN'(dbg_state), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);

        issue("post_rst_mul", MD_OP_MUL, MD_OUT_LO, 0, 0, 32'd3, 32'd4, 32'd12, 0, 34, 1);
        drain("final");
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vscale_mul_div_param.md
VSCALE_MUL_DIV_PARAM -- requirements
Module: vscale_mul_div_param

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 Parameter LOG2_XLEN, default $clog2(XLEN), iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  unit idle and able to accept a request.
REQ-007 req_op  input  MD_OP_WIDTH  MUL, DIV or REM.
REQ-008 req_out_sel  input  MD_OUT_SEL_WIDTH  LO, HI or REM result select.
REQ-009 req_in_1_signed, req_in_2_signed  input  1 each  operand signedness.
REQ-010 req_in_1, req_in_2  input  XLEN each  operands (dividend/divisor for DIV/REM).
REQ-011 req_kill  input  1  abort any in-flight operation.
REQ-012 resp_valid  output  1  result available.
REQ-013 resp_ready  input  1  consumer accepts result.
REQ-014 resp_result  output  XLEN  result.
REQ-015 resp_div_zero  output  1  current result came from a zero divisor; qualified by resp_valid.

Function
REQ-016 States SHALL be IDLE, COMPUTE, SETUP, DONE.
REQ-017 req_ready SHALL equal (state==IDLE); resp_valid SHALL equal (state==DONE).
REQ-018 IDLE->COMPUTE when req_valid=1 and divisor nonzero or op=MUL; IDLE->SETUP when req_valid=1, op is DIV/REM, req_in_2=0.
REQ-019 Accept cycle SHALL capture op, out_sel, absolute operands, signs, negate flag and load counter with XLEN-1.
REQ-020 COMPUTE SHALL process one bit per cycle for exactly XLEN cycles, then go to SETUP when counter==0.
REQ-021 MUL: shift-add on absolute values into a 2*XLEN product; LO selects bits [XLEN-1:0], HI selects [2*XLEN-1:XLEN].
REQ-022 DIV/REM: restoring division on absolute values producing XLEN-bit quotient and remainder.
REQ-023 Negation: MUL product and DIV quotient negated when sign_1 XOR sign_2; REM remainder negated when sign_1; sign_n = req_in_n_signed AND operand MSB.
REQ-024 Divide by zero: quotient SHALL be all ones, remainder SHALL be req_in_1 unmodified, resp_div_zero=1.
REQ-025 Signed overflow (most-negative / -1) SHALL yield quotient = most-negative value, remainder 0, with no special path.
REQ-026 SETUP SHALL register the selected, negated XLEN result into resp_result, then go to DONE.
REQ-027 Latency: accept at cycle 0, resp_valid at cycle XLEN+2 (normal), cycle 2 (divide by zero).
REQ-028 DONE SHALL hold resp_result and resp_div_zero stable while resp_ready=0; DONE->IDLE on resp_ready=1.
REQ-029 req_kill=1 in COMPUTE or SETUP SHALL force IDLE next cycle with no resp_valid; in DONE it SHALL drop the result; in IDLE it SHALL block acceptance that cycle.
REQ-030 req_valid while req_ready=0 SHALL be ignored; the requester holds it.
REQ-031 Illegal op/out_sel encodings SHALL complete with result 0.

Reset
REQ-032 Asserting reset SHALL immediately force state=IDLE, counter=0, resp_result=0, resp_div_zero=0, req_ready=1, resp_valid=0.
REQ-033 Reset asserted mid-operation SHALL discard the operation; the first post-reset request SHALL complete normally.
REQ-034 Datapath registers SHALL reset to zero; no X SHALL reach any output after reset.

Structure
REQ-035 A shared package SHALL hold MD_OP_WIDTH, MD_OUT_SEL_WIDTH, MD_OP_MUL/DIV/REM, MD_OUT_LO/HI/REM and the state enum.
REQ-036 One sub-module, vscale_md_abs_neg (XLEN-parametrised conditional absolute value/negate), SHALL be instantiated for operand and result sign handling.
REQ-037 State register and next-state logic SHALL be separate from datapath registers.

Verification (XLEN=32)
REQ-038 MUL LO signed, 7 x 0xFFFFFFFD -> 0xFFFFFFEB, resp_valid at cycle 34.
REQ-039 MUL HI signed x unsigned, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; signed x signed -> 0x00000000.
REQ-040 DIV signed 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-041 DIV 5 / 0 -> 0xFFFFFFFF with resp_div_zero=1 at cycle 2; REM 5 / 0 -> 5.
REQ-042 resp_ready low 3 cycles in DONE -> result held constant, req_ready=0 until handshake.
REQ-043 req_kill at COMPUTE cycle 10, then reset pulse mid-COMPUTE -> no resp_valid; next MUL 3 x 4 -> 12.
